// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-requester data memory arbiter:
// FSM encoding, requester indices and the data word width.
package data_mem_arbiter_pkg;

    localparam int WORD_W  = 24;
    localparam int REQ_CPU = 0;
    localparam int REQ_LDR = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester index to its bit in Gnt/Done/Err.
    function automatic logic [1:0] oneHot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of requester handshake and data memory bus signals.
// slave is the arbiter's view, master is the requesters-plus-memory view.
interface data_mem_arbiter_if;
    import data_mem_arbiter_pkg::*;

    logic [1:0]        Req;
    logic [1:0]        Write;
    logic [WORD_W-1:0] Addr0;
    logic [WORD_W-1:0] Addr1;
    logic [WORD_W-1:0] WData0;
    logic [WORD_W-1:0] WData1;
    logic [1:0]        Gnt;
    logic [1:0]        Done;
    logic [1:0]        Err;
    logic [WORD_W-1:0] RData;
    logic [WORD_W-1:0] MemAddress;
    logic [WORD_W-1:0] MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [WORD_W-1:0] MemReadData;

    modport slave (
        input  Req, Write, Addr0, Addr1, WData0, WData1, MemReadData,
        output Gnt, Done, Err, RData, MemAddress, MemWriteData, MemWrite, MemRead
    );

    modport master (
        output Req, Write, Addr0, Addr1, WData0, WData1, MemReadData,
        input  Gnt, Done, Err, RData, MemAddress, MemWriteData, MemWrite, MemRead
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic; the last-served pointer starts on the
// Loader so the CPU wins the first contended request after reset.
module rr_arbiter2
    import data_mem_arbiter_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       servedIdx,
    output logic [1:0] grant,
    output logic       winnerIdx
);

    logic lastServed;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            lastServed <= 1'(REQ_LDR);
        end else if (update) begin
            lastServed <= servedIdx;
        end
    end

    // On contention the requester that was not served last wins.
    always_comb begin
        winnerIdx = 1'(REQ_CPU);
        grant     = 2'b00;
        case (req)
            2'b01:   winnerIdx = 1'(REQ_CPU);
            2'b10:   winnerIdx = 1'(REQ_LDR);
            2'b11:   winnerIdx = (lastServed == 1'(REQ_LDR)) ? 1'(REQ_CPU) : 1'(REQ_LDR);
            default: winnerIdx = 1'(REQ_CPU);
        endcase
        if (req != 2'b00) begin
            grant = oneHot(winnerIdx);
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU and Loader access to a single-port byte-addressed data memory.
// All outputs are registered, so each appears in the cycle after the state that issues it.
module data_mem_arbiter #(
    parameter int MEM_BYTES = 128,
    parameter int WORD_W    = data_mem_arbiter_pkg::WORD_W
) (
    input  logic              Clock,
    input  logic              Reset,
    data_mem_arbiter_if.slave bus
);
    import data_mem_arbiter_pkg::*;

    // Highest legal start address of a 3-byte big-endian word.
    localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(MEM_BYTES - 3);

    state_t            state;
    logic              curIdx;
    logic              curWrite;
    logic              curErr;
    logic [1:0]        arbGrant;
    logic              winnerIdx;
    logic [WORD_W-1:0] winAddr;
    logic [WORD_W-1:0] winWData;

    rr_arbiter2 u_arb (
        .Clock     (Clock),
        .Reset     (Reset),
        .req       (bus.Req),
        .update    (state == RESP),
        .servedIdx (curIdx),
        .grant     (arbGrant),
        .winnerIdx (winnerIdx)
    );

    assign winAddr  = winnerIdx ? bus.Addr1  : bus.Addr0;
    assign winWData = winnerIdx ? bus.WData1 : bus.WData0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            curIdx           <= 1'b0;
            curWrite         <= 1'b0;
            curErr           <= 1'b0;
            bus.Gnt          <= 2'b00;
            bus.Done         <= 2'b00;
            bus.Err          <= 2'b00;
            bus.RData        <= '0;
            bus.MemAddress   <= '0;
            bus.MemWriteData <= '0;
            bus.MemWrite     <= 1'b0;
            bus.MemRead      <= 1'b0;
        end else begin
            bus.Gnt      <= 2'b00;
            bus.Done     <= 2'b00;
            bus.Err      <= 2'b00;
            bus.MemWrite <= 1'b0;
            bus.MemRead  <= 1'b0;
            // Read data is valid only while the read strobe is on the bus.
            if (bus.MemRead) begin
                bus.RData <= bus.MemReadData;
            end
            case (state)
                IDLE: begin
                    if (bus.Req != 2'b00) begin
                        bus.Gnt          <= arbGrant;
                        curIdx           <= winnerIdx;
                        curWrite         <= bus.Write[winnerIdx];
                        curErr           <= (winAddr > ADDR_LIMIT);
                        bus.MemAddress   <= winAddr;
                        bus.MemWriteData <= winWData;
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.MemWrite <= curWrite & ~curErr;
                    bus.MemRead  <= ~curWrite & ~curErr;
                    state        <= RESP;
                end
                RESP: begin
                    bus.Done <= oneHot(curIdx);
                    bus.Err  <= curErr ? oneHot(curIdx) : 2'b00;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge Clock) disable iff (Reset) $onehot0(bus.Gnt));
    assert property (@(posedge Clock) disable iff (Reset) $onehot0(bus.Done));
    assert property (@(posedge Clock) disable iff (Reset) $onehot0(bus.Err));
    assert property (@(posedge Clock) disable iff (Reset) !(bus.MemWrite && bus.MemRead));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a 128-byte
// big-endian memory model attached to the memory side of the bus.
module tb_data_mem_arbiter;

    logic Clock;
    logic Reset;
    logic memClear;
    int   checks;
    int   failures;

    logic [7:0] mem [0:127];

    data_mem_arbiter_if bus ();

    data_mem_arbiter #(
        .MEM_BYTES (128),
        .WORD_W    (24)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    always #5 Clock = ~Clock;

    // Combinational read port of the memory model.
    always_comb begin
        bus.MemReadData = 24'h000000;
        if (bus.MemAddress <= 24'd125) begin
            bus.MemReadData = {mem[bus.MemAddress[6:0]],
                               mem[bus.MemAddress[6:0] + 7'd1],
                               mem[bus.MemAddress[6:0] + 7'd2]};
        end
    end

    always @(posedge Clock) begin
        if (memClear) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else if (bus.MemWrite && bus.MemAddress <= 24'd125) begin
            mem[bus.MemAddress[6:0]]         <= bus.MemWriteData[23:16];
            mem[bus.MemAddress[6:0] + 7'd1]  <= bus.MemWriteData[15:8];
            mem[bus.MemAddress[6:0] + 7'd2]  <= bus.MemWriteData[7:0];
        end
    end

    // Gnt, Done and Err must never have more than one bit set.
    always @(negedge Clock) begin
        if (!Reset) begin
            checks++;
            if ($countones(bus.Gnt) > 1 || $countones(bus.Done) > 1 || $countones(bus.Err) > 1) begin
                failures++;
                $display("[TB] FAIL onehot0: got Gnt=%b Done=%b Err=%b expected at most one bit each",
                         bus.Gnt, bus.Done, bus.Err);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        Reset     = 1'b1;
        memClear  = 1'b1;
        bus.Req   = 2'b00;
        bus.Write = 2'b00;
        repeat (2) @(negedge Clock);
        checks += 8;
        if (bus.Gnt !== 2'b00)          begin failures++; $display("[TB] FAIL reset_gnt: got %b expected 00", bus.Gnt); end
        if (bus.Done !== 2'b00)         begin failures++; $display("[TB] FAIL reset_done: got %b expected 00", bus.Done); end
        if (bus.Err !== 2'b00)          begin failures++; $display("[TB] FAIL reset_err: got %b expected 00", bus.Err); end
        if (bus.MemWrite !== 1'b0)      begin failures++; $display("[TB] FAIL reset_memwrite: got %b expected 0", bus.MemWrite); end
        if (bus.MemRead !== 1'b0)       begin failures++; $display("[TB] FAIL reset_memread: got %b expected 0", bus.MemRead); end
        if (bus.RData !== 24'h0)        begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 000000", bus.RData); end
        if (bus.MemAddress !== 24'h0)   begin failures++; $display("[TB] FAIL reset_memaddr: got %h expected 000000", bus.MemAddress); end
        if (bus.MemWriteData !== 24'h0) begin failures++; $display("[TB] FAIL reset_memwdata: got %h expected 000000", bus.MemWriteData); end
        memClear = 1'b0;
        Reset    = 1'b0;
    endtask

    task automatic test_store();
        bus.Req    = 2'b01;
        bus.Write  = 2'b01;
        bus.Addr0  = 24'd4;
        bus.WData0 = 24'hABCDEF;
        for (int cy = 1; cy <= 3; cy++) begin
            @(negedge Clock);
            checks += 4;
            if (bus.Gnt !== ((cy == 1) ? 2'b01 : 2'b00)) begin failures++; $display("[TB] FAIL store_gnt c%0d: got %b", cy, bus.Gnt); end
            if (bus.MemWrite !== (cy == 2))              begin failures++; $display("[TB] FAIL store_memwrite c%0d: got %b", cy, bus.MemWrite); end
            if (bus.Done !== ((cy == 3) ? 2'b01 : 2'b00)) begin failures++; $display("[TB] FAIL store_done c%0d: got %b", cy, bus.Done); end
            if (bus.Err !== 2'b00)                       begin failures++; $display("[TB] FAIL store_err c%0d: got %b expected 00", cy, bus.Err); end
            if (cy == 2) begin
                checks += 2;
                if (bus.MemAddress !== 24'd4)        begin failures++; $display("[TB] FAIL store_addr: got %h expected 000004", bus.MemAddress); end
                if (bus.MemWriteData !== 24'hABCDEF) begin failures++; $display("[TB] FAIL store_wdata: got %h expected abcdef", bus.MemWriteData); end
            end
            if (cy == 1) bus.Req = 2'b00;
        end
        checks++;
        if ({mem[4], mem[5], mem[6]} !== 24'hABCDEF) begin
            failures++;
            $display("[TB] FAIL store_mem: got %h expected abcdef", {mem[4], mem[5], mem[6]});
        end
    endtask

    task automatic test_load();
        bus.Req   = 2'b01;
        bus.Write = 2'b00;
        bus.Addr0 = 24'd4;
        for (int cy = 1; cy <= 3; cy++) begin
            @(negedge Clock);
            checks += 4;
            if (bus.MemRead !== (cy == 2))               begin failures++; $display("[TB] FAIL load_memread c%0d: got %b", cy, bus.MemRead); end
            if (bus.MemWrite !== 1'b0)                   begin failures++; $display("[TB] FAIL load_memwrite c%0d: got %b expected 0", cy, bus.MemWrite); end
            if (bus.Done !== ((cy == 3) ? 2'b01 : 2'b00)) begin failures++; $display("[TB] FAIL load_done c%0d: got %b", cy, bus.Done); end
            if (bus.RData !== ((cy == 3) ? 24'hABCDEF : 24'h0)) begin failures++; $display("[TB] FAIL load_rdata c%0d: got %h", cy, bus.RData); end
            if (cy == 1) bus.Req = 2'b00;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expGnt  [1:12];
        logic [1:0] expDone [1:12];
        expGnt  = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        expDone = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset      = 1'b0;
        bus.Req    = 2'b11;
        bus.Write  = 2'b10;
        bus.Addr0  = 24'd4;
        bus.Addr1  = 24'd8;
        bus.WData1 = 24'h123456;
        for (int cy = 1; cy <= 12; cy++) begin
            @(negedge Clock);
            checks += 4;
            if (bus.Gnt !== expGnt[cy])   begin failures++; $display("[TB] FAIL rr_gnt c%0d: got %b expected %b", cy, bus.Gnt, expGnt[cy]); end
            if (bus.Done !== expDone[cy]) begin failures++; $display("[TB] FAIL rr_done c%0d: got %b expected %b", cy, bus.Done, expDone[cy]); end
            if (bus.MemWrite !== (cy == 5 || cy == 11)) begin failures++; $display("[TB] FAIL rr_memwrite c%0d: got %b", cy, bus.MemWrite); end
            if (bus.MemRead !== (cy == 2 || cy == 8))   begin failures++; $display("[TB] FAIL rr_memread c%0d: got %b", cy, bus.MemRead); end
            if (cy >= 3) begin
                checks++;
                if (bus.RData !== 24'hABCDEF) begin failures++; $display("[TB] FAIL rr_rdata c%0d: got %h expected abcdef", cy, bus.RData); end
            end
        end
        bus.Req = 2'b00;
        checks++;
        if ({mem[8], mem[9], mem[10]} !== 24'h123456) begin
            failures++;
            $display("[TB] FAIL rr_mem: got %h expected 123456", {mem[8], mem[9], mem[10]});
        end
    endtask

    task automatic test_out_of_range();
        bus.Req    = 2'b10;
        bus.Write  = 2'b10;
        bus.Addr1  = 24'd126;
        bus.WData1 = 24'h777777;
        for (int cy = 1; cy <= 3; cy++) begin
            @(negedge Clock);
            checks += 5;
            if (bus.Gnt !== ((cy == 1) ? 2'b10 : 2'b00))  begin failures++; $display("[TB] FAIL oor_gnt c%0d: got %b", cy, bus.Gnt); end
            if (bus.MemWrite !== 1'b0 || bus.MemRead !== 1'b0) begin failures++; $display("[TB] FAIL oor_strobe c%0d: got w=%b r=%b expected 0 0", cy, bus.MemWrite, bus.MemRead); end
            if (bus.Done !== ((cy == 3) ? 2'b10 : 2'b00)) begin failures++; $display("[TB] FAIL oor_done c%0d: got %b", cy, bus.Done); end
            if (bus.Err !== ((cy == 3) ? 2'b10 : 2'b00))  begin failures++; $display("[TB] FAIL oor_err c%0d: got %b", cy, bus.Err); end
            if (bus.RData !== 24'hABCDEF)                 begin failures++; $display("[TB] FAIL oor_rdata c%0d: got %h expected abcdef", cy, bus.RData); end
            if (cy == 1) bus.Req = 2'b00;
        end
        checks++;
        if (mem[126] !== 8'h00 || mem[127] !== 8'h00) begin
            failures++;
            $display("[TB] FAIL oor_mem: got %h%h expected 0000", mem[126], mem[127]);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.Req    = 2'b01;
        bus.Write  = 2'b01;
        bus.Addr0  = 24'd20;
        bus.WData0 = 24'h555555;
        @(negedge Clock);
        bus.Req = 2'b00;
        @(negedge Clock);
        checks++;
        if (bus.MemWrite !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_pre: got %b expected 1", bus.MemWrite); end
        #2 Reset = 1'b1;
        #1;
        checks += 2;
        if (bus.MemWrite !== 1'b0)     begin failures++; $display("[TB] FAIL rst_mid_async: got %b expected 0", bus.MemWrite); end
        if (bus.MemAddress !== 24'h0)  begin failures++; $display("[TB] FAIL rst_mid_addr: got %h expected 000000", bus.MemAddress); end
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        checks++;
        if ({mem[20], mem[21], mem[22]} !== 24'h000000) begin
            failures++;
            $display("[TB] FAIL rst_mid_mem: got %h expected 000000", {mem[20], mem[21], mem[22]});
        end
        for (int cy = 1; cy <= 2; cy++) begin
            @(negedge Clock);
            checks += 2;
            if (bus.Done !== 2'b00) begin failures++; $display("[TB] FAIL rst_mid_nodone c%0d: got %b expected 00", cy, bus.Done); end
            if (bus.Gnt !== 2'b00)  begin failures++; $display("[TB] FAIL rst_mid_idle c%0d: got %b expected 00", cy, bus.Gnt); end
        end
        bus.Req   = 2'b11;
        bus.Write = 2'b00;
        @(negedge Clock);
        bus.Req = 2'b00;
        checks++;
        if (bus.Gnt !== 2'b01) begin failures++; $display("[TB] FAIL rst_mid_cpu_first: got %b expected 01", bus.Gnt); end
        repeat (2) @(negedge Clock);
        checks++;
        if (bus.Done !== 2'b01) begin failures++; $display("[TB] FAIL rst_mid_done: got %b expected 01", bus.Done); end
    endtask

    task automatic test_drop_req();
        bus.Req   = 2'b01;
        bus.Write = 2'b00;
        bus.Addr0 = 24'd4;
        for (int cy = 1; cy <= 4; cy++) begin
            @(negedge Clock);
            checks += 2;
            if (bus.Gnt !== ((cy == 1) ? 2'b01 : 2'b00))  begin failures++; $display("[TB] FAIL drop_gnt c%0d: got %b", cy, bus.Gnt); end
            if (bus.Done !== ((cy == 3) ? 2'b01 : 2'b00)) begin failures++; $display("[TB] FAIL drop_done c%0d: got %b", cy, bus.Done); end
            if (cy == 1) bus.Req = 2'b00;
        end
    endtask

    initial begin
        Clock      = 1'b0;
        Reset      = 1'b1;
        memClear   = 1'b1;
        checks     = 0;
        failures   = 0;
        bus.Req    = 2'b00;
        bus.Write  = 2'b00;
        bus.Addr0  = 24'h0;
        bus.Addr1  = 24'h0;
        bus.WData0 = 24'h0;
        bus.WData1 = 24'h0;
        test_reset();
        test_store();
        test_load();
        test_round_robin();
        test_out_of_range();
        test_reset_mid_access();
        test_drop_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  MEM_BYTES  128  byte capacity of the attached data memory
  WORD_W     24   word width, 3 bytes, big-endian at Addr..Addr+2
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  Clock        in   1   single clock; all state on posedge
  Reset        in   1   asynchronous, active-high reset
  Req[1:0]     in   2   access request; bit0 = CPU, bit1 = Loader
  Write[1:0]   in   2   per-requester: 1 = store, 0 = load
  Addr0/Addr1  in   24  per-requester byte address
  WData0/WData1 in  24  per-requester store data
  Gnt[1:0]     out  2   one-hot grant, 1-cycle pulse
  Done[1:0]    out  2   transaction complete, 1-cycle pulse
  Err[1:0]     out  2   out-of-range flag, valid with Done
  RData        out  24  registered load data, valid with Done
  MemAddress   out  24  to data memory
  MemWriteData out  24  to data memory
  MemWrite     out  1   memory write strobe
  MemRead      out  1   memory read enable
  MemReadData  in   24  combinational read data from memory

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-004 In IDLE with any Req bit set, the block SHALL pulse Gnt for the winner, latch its Write/Addr/WData, and go to ACCESS next cycle.
REQ-005 Arbitration SHALL be round-robin: with both requesting, the winner is the requester not served last; with one requesting, that requester wins.
REQ-006 In ACCESS the block SHALL drive MemAddress/MemWriteData from the latched values and assert MemWrite (store) or MemRead (load) for exactly one cycle; the store commits on the posedge ending ACCESS.
REQ-007 In ACCESS the block SHALL register MemReadData into RData for loads; RData SHALL hold its value otherwise.
REQ-008 In RESP the block SHALL pulse Done for the served requester, update the last-served pointer, and return to IDLE.
REQ-009 Latency from Req sampled in IDLE to Done SHALL be 3 cycles; throughput SHALL be one transaction per 3 cycles; a new Gnt is possible in the cycle after RESP.
REQ-010 An address with Addr > MEM_BYTES-3 SHALL skip the memory strobe (MemWrite = MemRead = 0 in ACCESS), leave RData unchanged, and assert Err with Done.
REQ-011 Deasserting Req after Gnt SHALL NOT abort the transaction; Done still pulses.
REQ-012 Req changes during ACCESS/RESP SHALL be ignored until IDLE.
REQ-013 MemWrite and MemRead SHALL be 0 in IDLE and RESP; MemAddress/MemWriteData SHALL hold the latched values outside ACCESS.
REQ-014 Gnt, Done and Err SHALL each be one-hot-or-zero at all times.

Reset
REQ-015 Asserting Reset SHALL immediately force IDLE, Gnt = Done = Err = 0, MemWrite = MemRead = 0, RData = 0, MemAddress = MemWriteData = 0, and the last-served pointer to Loader, so the CPU wins first.
REQ-016 Reset during ACCESS SHALL drop MemWrite asynchronously; no Done is issued for the aborted transaction.

Structure
REQ-017 A shared package SHALL hold the state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2), the requester indices (REQ_CPU = 0, REQ_LDR = 1), and WORD_W.
REQ-018 One sub-module, rr_arbiter2 (2-input round-robin grant logic with a last-served pointer), SHALL be instantiated; all other logic SHALL be flat.

Verification
REQ-019 Reset, then Req = 01, Write0 = 1, Addr0 = 4, WData0 = 0xABCDEF: Gnt = 01 at cycle 1, MemWrite = 1 only at cycle 2, Done = 01 at cycle 3, Err = 0.
REQ-020 Then Req = 01, Write0 = 0, Addr0 = 4: Done = 01 at cycle 3 with RData = 0xABCDEF.
REQ-021 Req = 11 held for 12 cycles: grants follow CPU, Loader, CPU, Loader, 3 cycles apart.
REQ-022 Req = 10, Addr1 = 126, Write1 = 1: MemWrite stays 0; Done = 10 and Err = 10 at cycle 3.
REQ-023 Reset asserted mid-ACCESS of a store: MemWrite falls without waiting for a clock, no Done, IDLE after release; the next Req = 11 grants CPU first.
REQ-024 Req0 is dropped the cycle after Gnt: Done = 01 still appears at cycle 3.
